instr_mem_server: RTL

//   Responder side of the instruction-fetch interface: serves the CPU's PC-addressed fetches from on-chip

---
 rtl/instr_mem_server_pkg.sv | 14 +
 rtl/imem_ram.sv | 24 ++
 rtl/instr_mem_server.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instr_mem_server_pkg.sv
// Shared definitions for the instruction memory server:
// FSM state encoding, NOP word and default memory depth.
package instr_mem_server_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2
    } imem_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int IMEM_ADDR_WIDTH = 14;

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port synchronous word RAM: one write port,
// one read port with a single cycle of read latency.
module imem_ram #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_mem_server.sv
// Instruction fetch responder with UART program loader:
// serves PC fetches from word RAM, packs bytes into words.
module instr_mem_server
    import instr_mem_server_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pc,
    output logic [31:0]           instruction,
    output logic                  instr_valid,
    output logic                  cpu_stall,
    input  logic                  prog_mode,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic                  prog_done,
    output logic [ADDR_WIDTH:0]   prog_words,
    output logic                  prog_ovf,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH:0] PW_ONE = 1;

    imem_state_t state_q, state_d;

    logic [31:0]         rd_pc_q;
    logic                rd_vld_q;
    logic                rd_ok_q;
    logic [1:0]          bcnt_q;
    logic [23:0]         sh_q;
    logic [ADDR_WIDTH:0] pw_q;
    logic                ovf_q;

    logic                  run;
    logic                  word_done;
    logic                  ram_we;
    logic [31:0]           ram_rdata;
    logic [ADDR_WIDTH-1:0] ram_raddr;

    assign run       = (state_q == ST_RUN);
    assign ram_raddr = pc[ADDR_WIDTH+1:2];
    assign addr_err  = (pc[1:0] != 2'b00) ||
                       (pc[31:ADDR_WIDTH+2] != '0);

    // Fourth byte of a word; bytes arriving as the session closes are ignored
    assign word_done = (state_q == ST_LOAD) && prog_mode &&
                       rx_valid && (bcnt_q == 2'd3);
    assign ram_we    = word_done && !pw_q[ADDR_WIDTH];

    imem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(pw_q[ADDR_WIDTH-1:0]),
        .wdata({sh_q, rx_byte}),
        .re   (run),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (prog_mode) state_d = ST_LOAD;
            ST_LOAD:   if (!prog_mode) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pc_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_ok_q  <= 1'b0;
            bcnt_q   <= 2'd0;
            sh_q     <= '0;
            pw_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_pc_q  <= pc;
            rd_vld_q <= run;
            rd_ok_q  <= run && !addr_err;
            unique case (state_q)
                ST_RUN: begin
                    if (prog_mode) begin
                        bcnt_q <= 2'd0;
                        pw_q   <= '0;
                        ovf_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (prog_mode && rx_valid) begin
                        if (bcnt_q == 2'd3) begin
                            bcnt_q <= 2'd0;
                            if (pw_q[ADDR_WIDTH])
                                ovf_q <= 1'b1;
                            else
                                pw_q <= pw_q + PW_ONE;
                        end else begin
                            sh_q   <= {sh_q[15:0], rx_byte};
                            bcnt_q <= bcnt_q + 2'd1;
                        end
                    end
                end
                ST_FINISH: bcnt_q <= 2'd0;
                default: ;
            endcase
        end
    end

    assign instruction = rd_ok_q ? ram_rdata : NOP_WORD;
    assign instr_valid = run && rd_vld_q && (rd_pc_q == pc);
    assign cpu_stall   = !instr_valid;
    assign prog_done   = (state_q == ST_FINISH);
    assign prog_words  = pw_q;
    assign prog_ovf    = ovf_q;

endmodule
